mult_share_arb: RTL and testbench



---
 rtl/mult_arb_pkg.sv | 14 +
 rtl/mult_share_arb_rr_arbiter.sv | 40 ++++
 rtl/mult_share_arb.sv | 128 ++++++++++++
 tb/tb_mult_share_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared widths and types for the multiplier-sharing arbiter.
package mult_arb_pkg;

    localparam int DATA_W = 8;
    localparam int PROD_W = 16;
    localparam int STAT_W = 16;

    typedef logic signed [DATA_W-1:0] opnd_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic        [STAT_W-1:0] stat_t;

    localparam stat_t STAT_MAX = '1;

endpackage

// File: rtl/mult_share_arb_rr_arbiter.sv
// Round-robin grant search starting at rr_ptr; the pointer moves past the
// granted requester only when a transfer actually happens.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [ID_W-1:0]    grant,
    output logic               any_valid
);

    logic [ID_W-1:0] rr_ptr;

    always_comb begin : search
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                grant     = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one signed 8x8 multiplier among NUM_REQ requesters through a 2-stage
// pipeline. Define MULT_ARB_STATS_EN to add saturating grant/stall counters.
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic signed [DATA_W-1:0]  mul_a,
    output logic signed [DATA_W-1:0]  mul_b,
    input  logic signed [PROD_W-1:0]  mul_p,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic signed [PROD_W-1:0]  rsp_product
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_grant_cnt,
    output logic [STAT_W-1:0]         stat_stall_cnt,
    input  logic                      stat_clr
`endif
);

    logic            vld_p1, vld_p2;
    opnd_t           a_p1, b_p1;
    logic [ID_W-1:0] id_p1, id_p2;
    prod_t           p_p2;

    logic            s2_adv, s1_load, xfer, any_valid;
    logic [ID_W-1:0] grant;
    opnd_t           sel_a, sel_b;

    assign s2_adv  = vld_p1 & (!vld_p2 | rsp_ready);
    assign s1_load = !vld_p1 | s2_adv;
    assign xfer    = any_valid & s1_load;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (xfer),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = xfer;
        sel_a            = req_a[grant*DATA_W +: DATA_W];
        sel_b            = req_b[grant*DATA_W +: DATA_W];
    end

    // Stage S1: operands of the granted requester feed the shared multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            id_p1  <= '0;
        end else if (s1_load) begin
            vld_p1 <= xfer;
            if (xfer) begin
                a_p1  <= sel_a;
                b_p1  <= sel_b;
                id_p1 <= grant;
            end
        end
    end

    assign mul_a = a_p1;
    assign mul_b = b_p1;

    // Stage S2: registered product, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            p_p2   <= '0;
            id_p2  <= '0;
        end else if (s2_adv) begin
            vld_p2 <= 1'b1;
            p_p2   <= mul_p;
            id_p2  <= id_p1;
        end else if (rsp_ready) begin
            vld_p2 <= 1'b0;
        end
    end

    assign rsp_valid   = vld_p2;
    assign rsp_id      = id_p2;
    assign rsp_product = p_p2;

`ifdef MULT_ARB_STATS_EN
    function automatic stat_t sat_inc(stat_t c);
        return (c == STAT_MAX) ? c : c + 1'b1;
    endfunction

    stat_t grant_cnt [NUM_REQ];
    stat_t stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer) grant_cnt[grant] <= sat_inc(grant_cnt[grant]);
            if (vld_p2 && !rsp_ready) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        assign stat_grant_cnt[i*STAT_W +: STAT_W] = grant_cnt[i];
    end
    assign stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: per-requester drivers, a response
// monitor popping hand-computed expectations, directed scenarios in main.
module tb_mult_share_arb;

    localparam int NUM_REQ = 4;

    typedef struct packed {
        logic signed [7:0] a;
        logic signed [7:0] b;
    } op_t;

    typedef struct {
        int id;
        int prod;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NUM_REQ-1:0]  req_valid = '0;
    logic [NUM_REQ-1:0]  req_ready;
    logic [NUM_REQ-1:0]  acc = '0;
    logic [NUM_REQ*8-1:0] req_a = '0;
    logic [NUM_REQ*8-1:0] req_b = '0;
    logic signed [7:0]   mul_a, mul_b;
    logic signed [15:0]  mul_p;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic signed [15:0]  rsp_product;
`ifdef MULT_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] stat_grant_cnt;
    logic [15:0]           stat_stall_cnt;
    logic                  stat_clr;
`endif

    op_t  q_req [NUM_REQ][$];
    exp_t exp_q [$];
    logic flush = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    // Combinational stand-in for the shared multiplier
    assign mul_p = 16'(mul_a) * 16'(mul_b);

    mult_share_arb #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_p       (mul_p),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product)
`ifdef MULT_ARB_STATS_EN
        ,
        .stat_grant_cnt (stat_grant_cnt),
        .stat_stall_cnt (stat_stall_cnt),
        .stat_clr       (stat_clr)
`endif
    );

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    task automatic issue(int id, int a, int b, int p, bit expect_rsp);
        op_t o;
        o.a = 8'(a);
        o.b = 8'(b);
        q_req[id].push_back(o);
        if (expect_rsp) exp_q.push_back('{id, p});
    endtask

    task automatic drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(rsp_valid), 1);
    endtask

    task automatic wait_ready(string name, int id);
        int n = 0;
        while (!req_ready[id] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(req_ready[id]), 1);
    endtask

    always @(negedge clk) acc = rst_n ? (req_valid & req_ready) : '0;

    // Requester drivers: hold each operand pair until it is accepted
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush) begin
                req_valid[i] = 1'b0;
                q_req[i].delete();
            end else if (!req_valid[i] || acc[i]) begin
                if (q_req[i].size() > 0) begin
                    op_t o;
                    o = q_req[i].pop_front();
                    req_valid[i]    = 1'b1;
                    req_a[i*8 +: 8] = o.a;
                    req_b[i*8 +: 8] = o.b;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_id", int'(rsp_id), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", int'(rsp_id), e.id);
                chk("rsp_product", int'(rsp_product), e.prod);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
`ifdef MULT_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_product", int'(rsp_product), 0);
        chk("rst_mul_a", int'(mul_a), 0);
        chk("rst_mul_b", int'(mul_b), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single request with latency check
        issue(2, 5, -3, -15, 1'b1);
        wait_ready("single_accept", 2);
        @(negedge clk);
        chk("single_s1_rsp_valid", int'(rsp_valid), 0);
        chk("single_mul_a", int'(mul_a), 5);
        chk("single_mul_b", int'(mul_b), -3);
        @(negedge clk);
        chk("single_s2_rsp_valid", int'(rsp_valid), 1);
        drain("single");

        // Fairness from a fresh reset
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        issue(0, 1, 10, 10, 1'b1);
        issue(1, 2, 10, 20, 1'b1);
        issue(2, 3, 10, 30, 1'b1);
        issue(3, 4, 10, 40, 1'b1);
        issue(0, -1, 3, -3, 1'b1);
        issue(1, -2, 3, -6, 1'b1);
        issue(2, -3, 3, -9, 1'b1);
        issue(3, -4, 3, -12, 1'b1);
        wait_valid("fair_first_valid");
        for (int k = 0; k < 8; k++) begin
            chk("fair_back_to_back", int'(rsp_valid), 1);
            @(negedge clk);
        end
        drain("fair");

        // Extreme operands
        issue(0, -128, -128, 16384, 1'b1);
        issue(1, -128, 127, -16256, 1'b1);
        issue(2, 127, 127, 16129, 1'b1);
        issue(3, 0, -77, 0, 1'b1);
        drain("extremes");

        // Backpressure: both stages fill, requester 2 waits
        @(posedge clk); #2 rsp_ready = 1'b0;
        issue(0, 7, -8, -56, 1'b1);
        issue(1, -9, -9, 81, 1'b1);
        issue(2, 100, 3, 300, 1'b1);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_id", int'(rsp_id), 0);
            chk("bp_rsp_product", int'(rsp_product), -56);
            chk("bp_req_ready", int'(req_ready), 0);
            chk("bp_s1_held", int'(mul_a), -9);
            @(negedge clk);
        end
        @(posedge clk); #2 rsp_ready = 1'b1;
        drain("backpressure");

        // Reset with both stages occupied
        @(posedge clk); #2 rsp_ready = 1'b0;
        issue(1, 11, 11, 121, 1'b0);
        issue(2, 12, 12, 144, 1'b0);
        repeat (4) @(negedge clk);
        chk("rm_pre_rsp_valid", int'(rsp_valid), 1);
        #1 rst_n = 1'b0;
        flush = 1'b1;
        #1;
        chk("rm_rsp_valid", int'(rsp_valid), 0);
        chk("rm_rsp_product", int'(rsp_product), 0);
        chk("rm_mul_a", int'(mul_a), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        flush = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        issue(0, -4, 5, -20, 1'b1);
        issue(3, 2, 3, 6, 1'b1);
        drain("after_reset");

`ifdef MULT_ARB_STATS_EN
        @(posedge clk); #2 stat_clr = 1'b1;
        @(posedge clk); #2 stat_clr = 1'b0;
        for (int k = 1; k <= 10; k++) issue(1, k, 2, 2 * k, 1'b1);
        drain("stats_grants");
        @(posedge clk); #2 rsp_ready = 1'b0;
        issue(2, 3, 3, 9, 1'b1);
        wait_valid("stats_stall_valid");
        repeat (3) @(posedge clk);
        #2 rsp_ready = 1'b1;
        drain("stats_stall");
        @(negedge clk);
        chk("stat_grant_0", int'(stat_grant_cnt[15:0]), 0);
        chk("stat_grant_1", int'(stat_grant_cnt[31:16]), 10);
        chk("stat_grant_2", int'(stat_grant_cnt[47:32]), 1);
        chk("stat_grant_3", int'(stat_grant_cnt[63:48]), 0);
        chk("stat_stall", int'(stat_stall_cnt), 3);
        @(posedge clk); #2 stat_clr = 1'b1;
        @(negedge clk);
        chk("stat_stall_before_clr_edge", int'(stat_stall_cnt), 3);
        @(posedge clk); #1;
        chk("stat_grant_after_clr", int'(|stat_grant_cnt), 0);
        chk("stat_stall_after_clr", int'(stat_stall_cnt), 0);
        #1 stat_clr = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
